enet_cmd_arbiter: RTL and testbench

- Parametrised N-channel arbiter for the DM9000a command port. It sits between the command requesters (init, interrupt detector, RX, TX, external register access) and the EthernetController.
- Channel count, data/address widths and arbitration mode (fixed priority or round robin) are set by parameters.
- Grant is held until the owner releases its request and the controller returns ready, so a multi-command burst (e.g. an RX packet read) is never interleaved with another channel.

---
 rtl/enet_cmd_arbiter_if.sv | 40 ++++
 rtl/enet_cmd_arbiter.sv | 177 +++++++++++++++++
 tb/tb_enet_cmd_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enet_cmd_arbiter_if.sv
// Command-port bundle shared by the DM9000a requesters, the arbiter and the EthernetController.
// The arbiter takes the slave modport; requesters/controller side (or a bench) takes master.
interface enet_cmd_arbiter_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic [NUM_CH-1:0]        req_in;
    logic [NUM_CH-1:0]        start_comm_in;
    logic [NUM_CH*ADDR_W-1:0] addr_in;
    logic [NUM_CH*DATA_W-1:0] dataw_in;
    logic [NUM_CH*2-1:0]      comm_type_in;
    logic [NUM_CH*3-1:0]      post_delay_in;
    logic [NUM_CH-1:0]        grant_out;
    logic [2:0]               owner_idx_out;
    logic                     busy_out;
    logic                     timeout_out;
    logic                     enet_rdy_in;
    logic                     enet_start_command_out;
    logic [1:0]               enet_command_type_out;
    logic [ADDR_W-1:0]        enet_addr_out;
    logic [DATA_W-1:0]        enet_dataw_out;
    logic [2:0]               enet_post_command_delay_out;

    modport slave (
        input  req_in, start_comm_in, addr_in, dataw_in, comm_type_in, post_delay_in,
        input  enet_rdy_in,
        output grant_out, owner_idx_out, busy_out, timeout_out,
        output enet_start_command_out, enet_command_type_out, enet_addr_out,
        output enet_dataw_out, enet_post_command_delay_out
    );

    modport master (
        output req_in, start_comm_in, addr_in, dataw_in, comm_type_in, post_delay_in,
        output enet_rdy_in,
        input  grant_out, owner_idx_out, busy_out, timeout_out,
        input  enet_start_command_out, enet_command_type_out, enet_addr_out,
        input  enet_dataw_out, enet_post_command_delay_out
    );
endinterface

// File: rtl/enet_cmd_arbiter.sv
// N-channel DM9000a command-port arbiter (fixed priority or round robin), grant held per burst.
// Optional idle-grant watchdog enabled by defining ARB_TIMEOUT_EN.
module enet_cmd_arbiter #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    enet_cmd_arbiter_if.slave arb_if
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e              state_q;
    logic [NUM_CH-1:0]   grant_q;
    logic [2:0]          owner_q;
    logic [2:0]          ptr_q;
    logic                busy_q;

    logic [NUM_CH-1:0]   req_eff;
    logic [2*NUM_CH-1:0] req_dbl;
    logic [2:0]          rot;
    logic                win_vld_d;
    logic [2:0]          win_idx_d;
    logic [NUM_CH-1:0]   win_oh_d;
    logic [2:0]          ptr_nxt;

    logic                own_req;
    logic                own_start;
    logic                fwd_start;
    logic                tmo_hit;
    logic [ADDR_W-1:0]   mux_addr;
    logic [DATA_W-1:0]   mux_data;
    logic [1:0]          mux_type;
    logic [2:0]          mux_pdel;

    // Owner field mux; owner_q is 0 out of reset so channel 0 fields show.
    always_comb begin
        own_req   = 1'b0;
        own_start = 1'b0;
        mux_addr  = '0;
        mux_data  = '0;
        mux_type  = '0;
        mux_pdel  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (owner_q == 3'(i)) begin
                own_req   = arb_if.req_in[i];
                own_start = arb_if.start_comm_in[i];
                mux_addr  = arb_if.addr_in[i*ADDR_W +: ADDR_W];
                mux_data  = arb_if.dataw_in[i*DATA_W +: DATA_W];
                mux_type  = arb_if.comm_type_in[i*2 +: 2];
                mux_pdel  = arb_if.post_delay_in[i*3 +: 3];
            end
        end
    end

    assign fwd_start = (state_q == S_GRANT) && own_start && arb_if.enet_rdy_in;

    // Both modes share one scan: requests are rotated by the pointer (zero in fixed mode).
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_vld_d = 1'b0;
        win_idx_d = '0;
        rot       = (ARB_MODE == 1) ? ptr_q : 3'd0;
        req_dbl   = {req_eff, req_eff} >> rot;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!win_vld_d && req_dbl[k]) begin
                win_vld_d = 1'b1;
                idx       = 32'(rot) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                win_idx_d = 3'(idx);
            end
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            win_oh_d[i] = (win_idx_d == 3'(i));
        end
    end

    assign ptr_nxt = (owner_q == 3'(NUM_CH - 1)) ? 3'd0 : owner_q + 3'd1;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] mask_q;
    logic              timeout_q;
    logic              revoke;

    assign req_eff = arb_if.req_in & ~mask_q;
    assign tmo_hit = !fwd_start && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign revoke  = (state_q == S_GRANT) && own_req && tmo_hit;

    // A revoked channel stays masked until it lets go of its request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= revoke;
            mask_q    <= (mask_q & arb_if.req_in) | (revoke ? grant_q : '0);
            if ((state_q != S_GRANT) || fwd_start || revoke) cnt_q <= '0;
            else                                             cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign arb_if.timeout_out = timeout_q;
`else
    assign req_eff            = arb_if.req_in;
    assign tmo_hit            = 1'b0;
    assign arb_if.timeout_out = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_vld_d) begin
                        state_q <= S_GRANT;
                        grant_q <= win_oh_d;
                        owner_q <= win_idx_d;
                        busy_q  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (!own_req) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_nxt;
                        if (arb_if.enet_rdy_in) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else if (tmo_hit) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_nxt;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (arb_if.enet_rdy_in) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign arb_if.grant_out                   = grant_q;
    assign arb_if.owner_idx_out               = owner_q;
    assign arb_if.busy_out                    = busy_q;
    assign arb_if.enet_start_command_out      = fwd_start;
    assign arb_if.enet_command_type_out       = mux_type;
    assign arb_if.enet_addr_out               = mux_addr;
    assign arb_if.enet_dataw_out              = mux_data;
    assign arb_if.enet_post_command_delay_out = mux_pdel;
endmodule

// File: tb/tb_enet_cmd_arbiter.sv
// Bench for enet_cmd_arbiter: one fixed-priority and one round-robin instance on shared inputs.
// Watchdog scenario is exercised only when ARB_TIMEOUT_EN is defined.
module tb_enet_cmd_arbiter;
    localparam int NCH = 4;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NCH-1:0]    req, start;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] dataw;
    logic [NCH*2-1:0]  ctype;
    logic [NCH*3-1:0]  pdel;
    logic              rdy;

    enet_cmd_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) if0 ();
    enet_cmd_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) if1 ();

    assign if0.req_in = req;   assign if1.req_in = req;
    assign if0.start_comm_in = start; assign if1.start_comm_in = start;
    assign if0.addr_in = addr; assign if1.addr_in = addr;
    assign if0.dataw_in = dataw; assign if1.dataw_in = dataw;
    assign if0.comm_type_in = ctype; assign if1.comm_type_in = ctype;
    assign if0.post_delay_in = pdel; assign if1.post_delay_in = pdel;
    assign if0.enet_rdy_in = rdy; assign if1.enet_rdy_in = rdy;

    enet_cmd_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT_CYCLES(TMO))
        dut_fp (.clk_i(clk), .rst_ni(rst_n), .arb_if(if0.slave));
    enet_cmd_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT_CYCLES(TMO))
        dut_rr (.clk_i(clk), .rst_ni(rst_n), .arb_if(if1.slave));

    logic [NCH-1:0] o_gnt [2];
    logic [2:0]     o_own [2];
    logic           o_busy[2], o_tmo[2], o_start[2];
    logic [1:0]     o_type[2];
    logic [AW-1:0]  o_addr[2];
    logic [DW-1:0]  o_data[2];
    logic [2:0]     o_pdel[2];

    assign o_gnt[0] = if0.grant_out;   assign o_gnt[1] = if1.grant_out;
    assign o_own[0] = if0.owner_idx_out; assign o_own[1] = if1.owner_idx_out;
    assign o_busy[0] = if0.busy_out;   assign o_busy[1] = if1.busy_out;
    assign o_tmo[0] = if0.timeout_out; assign o_tmo[1] = if1.timeout_out;
    assign o_start[0] = if0.enet_start_command_out; assign o_start[1] = if1.enet_start_command_out;
    assign o_type[0] = if0.enet_command_type_out; assign o_type[1] = if1.enet_command_type_out;
    assign o_addr[0] = if0.enet_addr_out; assign o_addr[1] = if1.enet_addr_out;
    assign o_data[0] = if0.enet_dataw_out; assign o_data[1] = if1.enet_dataw_out;
    assign o_pdel[0] = if0.enet_post_command_delay_out; assign o_pdel[1] = if1.enet_post_command_delay_out;

    int checks   = 0;
    int failures = 0;

    // Reference model state: owner (-1 none), draining flag, last owner, pointer, watchdog.
    int             m_own [2];
    bit             m_drain[2];
    int             m_last[2];
    int             m_ptr [2];
    int             m_cnt [2];
    logic [NCH-1:0] m_mask[2];
    bit             m_tmo [2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NCH; i++) begin
            addr[i*AW +: AW]  = AW'($urandom);
            dataw[i*DW +: DW] = DW'($urandom);
            ctype[i*2 +: 2]   = 2'($urandom);
            pdel[i*3 +: 3]    = 3'($urandom);
        end
    endtask

    task automatic do_reset();
        req = '0; start = '0; rdy = 1'b1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    function automatic int pick(int mode, logic [NCH-1:0] eff, int ptr);
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (mode == 1) ? (ptr + k) % NCH : k;
            if (eff[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_init();
        for (int d = 0; d < 2; d++) begin
            m_own[d] = -1; m_drain[d] = 0; m_last[d] = 0; m_ptr[d] = 0;
            m_cnt[d] = 0; m_mask[d] = '0; m_tmo[d] = 0;
        end
    endtask

    task automatic model_clock(int d);
        logic [NCH-1:0] nmask;
        int o, w;
        nmask    = m_mask[d] & req;
        m_tmo[d] = 0;
        if (m_own[d] < 0) begin
            if (m_drain[d]) begin
                if (rdy) m_drain[d] = 0;
            end else begin
                w = pick(d, req & ~m_mask[d], m_ptr[d]);
                if (w >= 0) begin m_own[d] = w; m_last[d] = w; m_cnt[d] = 0; end
            end
        end else begin
            o = m_own[d];
            if (!req[o]) begin
                m_own[d] = -1; m_drain[d] = !rdy; m_ptr[d] = (o + 1) % NCH;
            end
`ifdef ARB_TIMEOUT_EN
            else if (start[o] && rdy) m_cnt[d] = 0;
            else if (m_cnt[d] + 1 == TMO) begin
                m_own[d] = -1; m_drain[d] = 1; m_ptr[d] = (o + 1) % NCH;
                nmask[o] = 1'b1; m_tmo[d] = 1;
            end else m_cnt[d] = m_cnt[d] + 1;
`endif
        end
        m_mask[d] = nmask;
    endtask

    task automatic test_reset();
        req = '0; start = '1; rdy = 1'b1; rand_fields();
        rst_n = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            if (o_gnt[d] !== '0) begin failures++; $display("FAIL reset_grant dut%0d got=%b exp=0000", d, o_gnt[d]); end
            checks++;
            if (o_busy[d] !== 1'b0 || o_tmo[d] !== 1'b0 || o_own[d] !== 3'd0) begin
                failures++; $display("FAIL reset_status dut%0d busy=%b tmo=%b own=%0d exp=0/0/0", d, o_busy[d], o_tmo[d], o_own[d]);
            end
            checks++;
            if (o_start[d] !== 1'b0 || o_addr[d] !== addr[AW-1:0] || o_data[d] !== dataw[DW-1:0]) begin
                failures++; $display("FAIL reset_mux dut%0d start=%b addr=%h data=%h exp=0/%h/%h", d, o_start[d], o_addr[d], o_data[d], addr[AW-1:0], dataw[DW-1:0]);
            end
            checks++;
        end
        start = '0; rst_n = 1'b1; req = 4'b0100;
        step();
        for (int d = 0; d < 2; d++) begin
            if (o_gnt[d] !== 4'b0100) begin failures++; $display("FAIL first_grant dut%0d got=%b exp=0100", d, o_gnt[d]); end
            checks++;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (o_gnt[d] !== '0 || o_busy[d] !== 1'b0) begin
                failures++; $display("FAIL async_reset dut%0d grant=%b busy=%b exp=0000/0", d, o_gnt[d], o_busy[d]);
            end
            checks++;
        end
        rst_n = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            if (o_gnt[d] !== 4'b0100) begin failures++; $display("FAIL regrant_after_reset dut%0d got=%b exp=0100", d, o_gnt[d]); end
            checks++;
        end
        req = '0; step(); step();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        req = 4'b1010;
        step();
        if (o_gnt[0] !== 4'b0010 || o_own[0] !== 3'd1 || o_busy[0] !== 1'b1) begin
            failures++; $display("FAIL fp_lowest grant=%b own=%0d busy=%b exp=0010/1/1", o_gnt[0], o_own[0], o_busy[0]);
        end
        checks++;
        req = 4'b1011; step(); step();
        if (o_gnt[0] !== 4'b0010) begin failures++; $display("FAIL fp_no_preempt got=%b exp=0010", o_gnt[0]); end
        checks++;
        req = 4'b1000;
        step();
        if (o_gnt[0] !== '0 || o_busy[0] !== 1'b0 || o_own[0] !== 3'd1) begin
            failures++; $display("FAIL fp_idle_gap grant=%b busy=%b own=%0d exp=0000/0/1", o_gnt[0], o_busy[0], o_own[0]);
        end
        checks++;
        step();
        if (o_gnt[0] !== 4'b1000 || o_own[0] !== 3'd3) begin
            failures++; $display("FAIL fp_next_owner grant=%b own=%0d exp=1000/3", o_gnt[0], o_own[0]);
        end
        checks++;
        req = '0; step(); step();
    endtask

    task automatic test_round_robin();
        int order[5];
        order = '{0, 1, 2, 3, 0};
        do_reset();
        req = '1;
        step();
        for (int i = 0; i < 5; i++) begin
            if (o_gnt[1] !== 4'(1 << order[i]) || o_own[1] !== 3'(order[i])) begin
                failures++; $display("FAIL rr_order step%0d grant=%b own=%0d exp_owner=%0d", i, o_gnt[1], o_own[1], order[i]);
            end
            checks++;
            start = 4'(1 << order[i]);
            #1;
            if (o_start[1] !== 1'b1) begin failures++; $display("FAIL rr_strobe step%0d got=%b exp=1", i, o_start[1]); end
            checks++;
            step(); step();
            start = '0; req = ~4'(1 << order[i]);
            step();
            if (o_gnt[1] !== '0) begin failures++; $display("FAIL rr_release step%0d got=%b exp=0000", i, o_gnt[1]); end
            checks++;
            req = '1;
            step();
        end
        req = '0; step(); step();
    endtask

    task automatic test_mux_start();
        do_reset();
        rand_fields();
        addr[3*AW +: AW] = 8'h05; dataw[3*DW +: DW] = 16'hABCD;
        ctype[3*2 +: 2] = 2'd1;   pdel[3*3 +: 3] = 3'd5;
        req = 4'b1000;
        step();
        if (o_gnt[0] !== 4'b1000) begin failures++; $display("FAIL mux_grant got=%b exp=1000", o_gnt[0]); end
        checks++;
        start = 4'b1000; rdy = 1'b0;
        #1;
        if (o_start[0] !== 1'b0) begin failures++; $display("FAIL start_not_ready got=%b exp=0", o_start[0]); end
        checks++;
        rdy = 1'b1;
        #1;
        if (o_start[0] !== 1'b1 || o_addr[0] !== 8'h05 || o_data[0] !== 16'hABCD || o_type[0] !== 2'd1 || o_pdel[0] !== 3'd5) begin
            failures++; $display("FAIL mux_fields start=%b addr=%h data=%h type=%0d pdel=%0d exp=1/05/abcd/1/5", o_start[0], o_addr[0], o_data[0], o_type[0], o_pdel[0]);
        end
        checks++;
        start = 4'b0001;
        #1;
        if (o_start[0] !== 1'b0) begin failures++; $display("FAIL nonowner_start got=%b exp=0", o_start[0]); end
        checks++;
        start = 4'b1000; req = '0;
        #1;
        if (o_start[0] !== 1'b1) begin failures++; $display("FAIL start_on_release got=%b exp=1", o_start[0]); end
        checks++;
        step();
        if (o_gnt[0] !== '0 || o_busy[0] !== 1'b0) begin
            failures++; $display("FAIL release_idle grant=%b busy=%b exp=0000/0", o_gnt[0], o_busy[0]);
        end
        checks++;
        start = '0; step();
    endtask

    task automatic test_drain();
        do_reset();
        req = 4'b0001;
        step();
        if (o_gnt[0] !== 4'b0001) begin failures++; $display("FAIL drain_setup got=%b exp=0001", o_gnt[0]); end
        checks++;
        req = 4'b0010; rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (o_gnt[0] !== '0 || o_busy[0] !== 1'b1) begin
                failures++; $display("FAIL drain_hold cycle%0d grant=%b busy=%b exp=0000/1", c, o_gnt[0], o_busy[0]);
            end
            checks++;
        end
        rdy = 1'b1;
        step();
        if (o_gnt[0] !== '0 || o_busy[0] !== 1'b0) begin
            failures++; $display("FAIL drain_exit grant=%b busy=%b exp=0000/0", o_gnt[0], o_busy[0]);
        end
        checks++;
        step();
        if (o_gnt[0] !== 4'b0010) begin failures++; $display("FAIL drain_next got=%b exp=0010", o_gnt[0]); end
        checks++;
        req = '0; step(); step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 4'b0001;
        step();
        for (int c = 1; c < TMO; c++) begin
            step();
            if (o_gnt[0] !== 4'b0001 || o_tmo[0] !== 1'b0) begin
                failures++; $display("FAIL tmo_early cycle%0d grant=%b tmo=%b exp=0001/0", c, o_gnt[0], o_tmo[0]);
            end
            checks++;
        end
        step();
        if (o_gnt[0] !== '0 || o_tmo[0] !== 1'b1 || o_busy[0] !== 1'b1) begin
            failures++; $display("FAIL tmo_revoke grant=%b tmo=%b busy=%b exp=0000/1/1", o_gnt[0], o_tmo[0], o_busy[0]);
        end
        checks++;
        req = 4'b0011;
        step();
        if (o_tmo[0] !== 1'b0) begin failures++; $display("FAIL tmo_pulse_width got=%b exp=0", o_tmo[0]); end
        checks++;
        step();
        if (o_gnt[0] !== 4'b0010) begin failures++; $display("FAIL tmo_mask got=%b exp=0010", o_gnt[0]); end
        checks++;
        req = '0; step(); step();
    endtask
`endif

    task automatic test_random();
        int nfail;
        int o;
        logic [NCH-1:0] e_gnt;
        logic           e_start, e_busy;
        nfail = 0;
        do_reset();
        model_init();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                start[i] = ($urandom_range(0, 3) == 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            rand_fields();
            #1;
            for (int d = 0; d < 2; d++) begin
                o       = m_own[d];
                e_gnt   = (o >= 0) ? 4'(1 << o) : 4'b0000;
                e_busy  = (o >= 0) || m_drain[d];
                e_start = (o >= 0) && start[o] && rdy;
                if (o_gnt[d] !== e_gnt || o_busy[d] !== e_busy || o_own[d] !== 3'(m_last[d]) || o_tmo[d] !== m_tmo[d]) begin
                    failures++; nfail++;
                    $display("FAIL rand_state dut%0d cyc%0d grant=%b busy=%b own=%0d tmo=%b exp=%b/%b/%0d/%b",
                             d, cyc, o_gnt[d], o_busy[d], o_own[d], o_tmo[d], e_gnt, e_busy, m_last[d], m_tmo[d]);
                end
                checks++;
                if (o_start[d] !== e_start || o_addr[d] !== addr[m_last[d]*AW +: AW] || o_data[d] !== dataw[m_last[d]*DW +: DW]
                    || o_type[d] !== ctype[m_last[d]*2 +: 2] || o_pdel[d] !== pdel[m_last[d]*3 +: 3]) begin
                    failures++; nfail++;
                    $display("FAIL rand_mux dut%0d cyc%0d start=%b addr=%h data=%h exp_start=%b exp_addr=%h exp_data=%h",
                             d, cyc, o_start[d], o_addr[d], o_data[d], e_start, addr[m_last[d]*AW +: AW], dataw[m_last[d]*DW +: DW]);
                end
                checks++;
                model_clock(d);
            end
            if (nfail > 20) break;
            step();
        end
        req = '0; start = '0; rdy = 1'b1;
        step(); step();
    endtask

    initial begin
        req = '0; start = '0; rdy = 1'b1; rst_n = 1'b0;
        addr = '0; dataw = '0; ctype = '0; pdel = '0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_mux_start();
        test_drain();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
